// File: rtl/weight_load_sequencer.sv
// Weight-load sequencer: walks every (layer,row) pair layer-major, one is_load strobe per pair.
// Optional abort/aborted ports are enabled by defining WEIGHT_LOAD_ABORT_EN.
module weight_load_sequencer #(
  parameter int INDEX_WIDTH = 32,
  parameter int MAX_LAYERS  = 16,
  parameter int MAX_ROWS    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [31:0]            cfg_layers,
  input  logic [31:0]            cfg_rows,
  input  logic                   hold,
`ifdef WEIGHT_LOAD_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   is_load,
  output logic [INDEX_WIDTH-1:0] w_row_index,
  output logic [INDEX_WIDTH-1:0] w_layer_index
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [31:0]            layers_q, layers_d;
  logic [31:0]            rows_q, rows_d;
  logic [31:0]            l_q, l_d;
  logic [31:0]            r_q, r_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   is_load_q, is_load_d;
  logic [INDEX_WIDTH-1:0] w_row_q, w_row_d;
  logic [INDEX_WIDTH-1:0] w_layer_q, w_layer_d;

  logic [31:0] layers_clamp, rows_clamp;
  logic [31:0] cur_l, cur_r, cur_layers, cur_rows;
  logic        issue;
  logic        abort_req;

  assign layers_clamp = (cfg_layers > 32'(MAX_LAYERS)) ? 32'(MAX_LAYERS) : cfg_layers;
  assign rows_clamp   = (cfg_rows > 32'(MAX_ROWS)) ? 32'(MAX_ROWS) : cfg_rows;

`ifdef WEIGHT_LOAD_ABORT_EN
  logic aborted_q, aborted_d;

  assign abort_req = abort;
  // An abort after the final issue is not a cut-short sweep.
  assign aborted_d = (state_q == LOAD) && abort && !last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aborted_q <= 1'b0;
    else        aborted_q <= aborted_d;
  end

  assign aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // l_q/r_q point at the next pair to issue; last_q marks that the final pair is out.
  always_comb begin
    state_d    = state_q;
    layers_d   = layers_q;
    rows_d     = rows_q;
    l_d        = l_q;
    r_d        = r_q;
    last_d     = last_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    is_load_d  = 1'b0;
    w_row_d    = w_row_q;
    w_layer_d  = w_layer_q;
    cur_l      = l_q;
    cur_r      = r_q;
    cur_layers = layers_q;
    cur_rows   = rows_q;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          layers_d = layers_clamp;
          rows_d   = rows_clamp;
          l_d      = '0;
          r_d      = '0;
          last_d   = 1'b0;
          if ((layers_clamp == '0) || (rows_clamp == '0)) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = LOAD;
            busy_d     = 1'b1;
            cur_l      = '0;
            cur_r      = '0;
            cur_layers = layers_clamp;
            cur_rows   = rows_clamp;
            issue      = !hold;
          end
        end
      end
      LOAD: begin
        if (abort_req || last_q) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          issue  = !hold;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      is_load_d = 1'b1;
      w_layer_d = INDEX_WIDTH'(cur_l);
      w_row_d   = INDEX_WIDTH'(cur_r);
      if (cur_r == cur_rows - 32'd1) begin
        r_d = '0;
        if (cur_l == cur_layers - 32'd1) last_d = 1'b1;
        else                             l_d    = cur_l + 32'd1;
      end else begin
        r_d = cur_r + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      layers_q  <= '0;
      rows_q    <= '0;
      l_q       <= '0;
      r_q       <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_load_q <= 1'b0;
      w_row_q   <= '0;
      w_layer_q <= '0;
    end else begin
      state_q   <= state_d;
      layers_q  <= layers_d;
      rows_q    <= rows_d;
      l_q       <= l_d;
      r_q       <= r_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      is_load_q <= is_load_d;
      w_row_q   <= w_row_d;
      w_layer_q <= w_layer_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign is_load       = is_load_q;
  assign w_row_index   = w_row_q;
  assign w_layer_index = w_layer_q;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Self-checking bench for weight_load_sequencer: directed sweeps plus randomized sweeps
// checked against a queue of expected (layer,row) pairs built from nested loops.
module tb_weight_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_layers = '0;
  logic [31:0] cfg_rows = '0;
  logic        hold = 1'b0;
  logic        busy, done, is_load;
  logic [31:0] w_row_index, w_layer_index;
`ifdef WEIGHT_LOAD_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
`endif

  int tests = 0;
  int failed = 0;
  int lastL = 0;
  int lastR = 0;

  weight_load_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_layers(cfg_layers),
    .cfg_rows(cfg_rows),
    .hold(hold),
`ifdef WEIGHT_LOAD_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .busy(busy),
    .done(done),
    .is_load(is_load),
    .w_row_index(w_row_index),
    .w_layer_index(w_layer_index)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed no end expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full sweep. Inputs change #1 after each rising edge; cycle 0 is the start cycle.
  task automatic applyStimulus(input logic [31:0] lay, input logic [31:0] rows, input bit rnd,
                               input logic [15:0] mask, output int loads);
    int qL[$];
    int qR[$];
    int cl, cr, budget, cyc, eL, eR;
    bit holdPrev, finished;
    cl = (lay > 32'd16) ? 16 : int'(lay);
    cr = (rows > 32'd64) ? 64 : int'(rows);
    for (int l = 0; l < cl; l++)
      for (int r = 0; r < cr; r++) begin
        qL.push_back(l);
        qR.push_back(r);
      end
    cfg_layers = lay;
    cfg_rows   = rows;
    start      = 1'b1;
    hold       = rnd ? ($urandom_range(0, 3) == 0) : mask[0];
    holdPrev   = hold;
    finished   = 0;
    loads      = 0;
    cyc        = 0;
    budget     = cl * cr * 8 + 20;
    while (!finished && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
      cyc++;
      if (qL.size() == 0) begin
        checkOutput("doneAtEnd", done, 1);
        checkOutput("loadAtDone", is_load, 0);
        checkOutput("busyAtDone", busy, 0);
`ifdef WEIGHT_LOAD_ABORT_EN
        checkOutput("abortedFull", aborted, 0);
`endif
        finished = 1;
      end else begin
        checkOutput("doneEarly", done, 0);
        checkOutput("busySweep", busy, 1);
        checkOutput("isLoad", is_load, !holdPrev);
        if (!holdPrev) begin
          eL = qL.pop_front();
          eR = qR.pop_front();
          lastL = eL;
          lastR = eR;
          loads++;
        end
        checkOutput("layerIdx", w_layer_index, lastL);
        checkOutput("rowIdx", w_row_index, lastR);
      end
      if (finished) begin
        start = 1'b0;
        hold  = 1'b0;
      end else begin
        // Stray starts and config changes mid-sweep must be ignored.
        start      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        cfg_layers = rnd ? $urandom : lay;
        cfg_rows   = rnd ? $urandom : rows;
        hold       = rnd ? ($urandom_range(0, 3) == 0) : ((cyc < 16) ? mask[cyc] : 1'b0);
        holdPrev   = hold;
      end
    end
    if (!finished) checkOutput("sweepTimeout", 0, 1);
    start = 1'b0;
    hold  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("doneOneCycle", done, 0);
    checkOutput("busyAfter", busy, 0);
    checkOutput("loadAfter", is_load, 0);
  endtask

  initial begin
    int loads;
    $display("[TB] weight_load_sequencer bench starting");

    #12;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstLoad", is_load, 0);
    checkOutput("rstRow", w_row_index, 0);
    checkOutput("rstLayer", w_layer_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(32'd2, 32'd3, 0, 16'h0000, loads);
    checkOutput("loads2x3", loads, 6);
    checkOutput("last2x3L", lastL, 1);
    checkOutput("last2x3R", lastR, 2);

    applyStimulus(32'd1, 32'd4, 0, 16'b0110, loads);
    checkOutput("loads1x4Hold", loads, 4);

    applyStimulus(32'd0, 32'd5, 0, 16'h0000, loads);
    checkOutput("loadsZero", loads, 0);

    applyStimulus(32'd100, 32'd2, 0, 16'h0000, loads);
    checkOutput("loadsClamp", loads, 32);
    checkOutput("lastClampL", lastL, 15);
    checkOutput("lastClampR", lastR, 1);

    cfg_layers = 32'd2;
    cfg_rows   = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstLoad", is_load, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstRow", w_row_index, 0);
    checkOutput("midRstLayer", w_layer_index, 0);
    lastL = 0;
    lastR = 0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("noDoneAfterRst", done, 0);
      checkOutput("idleAfterRst", busy, 0);
    end
    applyStimulus(32'd2, 32'd3, 0, 16'h0000, loads);
    checkOutput("loadsAfterRst", loads, 6);

`ifdef WEIGHT_LOAD_ABORT_EN
    cfg_layers = 32'd4;
    cfg_rows   = 32'd4;
    start      = 1'b1;
    loads      = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (is_load) loads++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abortDone", done, 1);
    checkOutput("abortFlag", aborted, 1);
    checkOutput("abortLoad", is_load, 0);
    checkOutput("abortLoads", loads, 4);
    lastL = 0;
    lastR = 3;
    @(posedge clk);
    #1;
    checkOutput("abortDonePulse", done, 0);
    applyStimulus(32'd4, 32'd4, 0, 16'h0000, loads);
    checkOutput("loadsPostAbort", loads, 16);
`endif

    for (int n = 0; n < 25; n++) begin
      logic [31:0] lay, rows;
      lay  = (n % 6 == 5) ? 32'($urandom_range(17, 40)) : 32'($urandom_range(0, 6));
      rows = (n % 8 == 7) ? 32'($urandom_range(60, 90)) : 32'($urandom_range(0, 8));
      if (n % 8 == 7) lay = 32'd1;
      applyStimulus(lay, rows, 1, 16'h0000, loads);
      checkOutput("loadsRandom", loads,
                  ((lay > 32'd16) ? 32'd16 : lay) * ((rows > 32'd64) ? 32'd64 : rows));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
